// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
//
// Handshake: md_start is a request that is taken only when the unit sits in
// IDLE (md_busy low). md_busy low means the unit is ready for a request.
// Operands need only be valid in the md_start cycle. md_done is a one-cycle
// result strobe with hi/lo already updated; it never overlaps md_busy.
// md_cancel flushes an in-flight operation and is ignored while idle.
interface muldiv_unit_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        md_cancel;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  md_state;  // FSM state for debug/checkers: 0 IDLE, 1 MUL, 2 DIV, 3 FIX

  modport master (
    output md_start, md_op, md_src1, md_src2, md_cancel,
    input  md_busy, md_done, hi, lo, md_state
  );

  modport slave (
    input  md_start, md_op, md_src1, md_src2, md_cancel,
    output md_busy, md_done, hi, lo, md_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, followed by a sign fix-up cycle that
// writes the HI/LO pair. Also handles MTHI/MTLO direct writes.
module muldiv_unit (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [4:0]  r_cnt;
  logic [31:0] r_a;          // multiplicand / divisor magnitude
  logic [31:0] r_b;          // multiplier shifting out, product low half; dividend shifting out, quotient in
  logic [31:0] r_acc;        // product high half / partial remainder
  logic        r_is_div;
  logic        r_neg_res;    // product or quotient must be negated
  logic        r_neg_rem;    // remainder takes dividend sign
  logic        r_div_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic        w_start_mul;
  logic        w_start_div;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic        w_signed_op;
  logic        w_neg1;
  logic        w_neg2;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_trial;
  logic        w_q_bit;
  logic [31:0] w_div_sub;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [63:0] w_result;
  logic        w_commit;

  // Request decode: only IDLE listens to md_start; ops 110/111 fall through.
  assign w_accept    = (r_state == S_IDLE) && bus.md_start;
  assign w_start_mul = w_accept && (bus.md_op[2:1] == 2'b00);
  assign w_start_div = w_accept && (bus.md_op[2:1] == 2'b01);
  assign w_wr_hi     = w_accept && (bus.md_op == 3'b100);
  assign w_wr_lo     = w_accept && (bus.md_op == 3'b101);

  // MULT and DIV (op bit 0 clear) work on magnitudes and remember the signs.
  assign w_signed_op = ~bus.md_op[0];
  assign w_neg1      = w_signed_op && bus.md_src1[31];
  assign w_neg2      = w_signed_op && bus.md_src2[31];
  assign w_abs1      = w_neg1 ? (32'd0 - bus.md_src1) : bus.md_src1;
  assign w_abs2      = w_neg2 ? (32'd0 - bus.md_src2) : bus.md_src2;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the 65-bit {carry, acc, b} right by one.
  assign w_mul_sum   = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : 33'd0);

  // Restoring step: bring in the next dividend bit and subtract if it fits.
  // The difference is below the divisor, so 32 bits hold it exactly.
  assign w_div_trial = {r_acc, r_b[31]};
  assign w_q_bit     = (w_div_trial >= {1'b0, r_a});
  assign w_div_sub   = w_div_trial[31:0] - r_a;

  // Sign fix-up. A zero divisor leaves quotient all ones; the remainder is the
  // dividend magnitude, so re-applying the dividend sign restores md_src1.
  assign w_prod      = {r_acc, r_b};
  assign w_prod_fix  = r_neg_res ? (64'd0 - w_prod) : w_prod;
  assign w_quo_fix   = (r_neg_res && !r_div_zero) ? (32'd0 - r_b) : r_b;
  assign w_rem_fix   = r_neg_rem ? (32'd0 - r_acc) : r_acc;
  assign w_result    = r_is_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;
  assign w_commit    = (r_state == S_FIX) && !bus.md_cancel;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; cancel beats both iteration and completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul)      w_state_nxt = S_MUL;
        else if (w_start_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (bus.md_cancel)        w_state_nxt = S_IDLE;
        else if (r_cnt == 5'd31)  w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch and per-cycle iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 5'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_acc      <= 32'd0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul || w_start_div) begin
            r_cnt      <= 5'd0;
            r_a        <= w_abs2;
            r_b        <= w_abs1;
            r_acc      <= 32'd0;
            r_is_div   <= bus.md_op[1];
            r_neg_res  <= w_neg1 ^ w_neg2;
            r_neg_rem  <= w_neg1;
            r_div_zero <= (bus.md_src2 == 32'd0);
          end
        end
        S_MUL: begin
          r_acc <= w_mul_sum[32:1];
          r_b   <= {w_mul_sum[0], r_b[31:1]};
          r_cnt <= r_cnt + 5'd1;
        end
        S_DIV: begin
          r_acc <= w_q_bit ? w_div_sub : w_div_trial[31:0];
          r_b   <= {r_b[30:0], w_q_bit};
          r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO: written only by a completing FIX or an MTHI/MTLO accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      r_hi <= w_result[63:32];
      r_lo <= w_result[31:0];
    end else if (w_wr_hi) begin
      r_hi <= bus.md_src1;
    end else if (w_wr_lo) begin
      r_lo <= bus.md_src1;
    end
  end

  // Registered status: busy follows the upcoming state, done marks a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_commit;
    end
  end

  assign bus.md_busy  = r_busy;
  assign bus.md_done  = r_done;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.md_state = r_state;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the execute stage. It takes the same rs/rt operand pair that feeds the ALU and produces the HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Multiplies and divides run one bit per cycle. While the unit is busy it stalls the single-cycle datapath, and writeback reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
Parameters:
- none; datapath width is fixed at 32 bits.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `md_start`  in  1  request strobe; sampled only in IDLE.
- `md_op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored.
- `md_src1`  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data).
- `md_src2`  in  32  rt operand (multiplier / divisor).
- `md_cancel`  in  1  exception flush; aborts an in-flight operation.
- `md_busy`  out  1  high while an iterative op is in flight; drives the pipeline stall.
- `md_done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result in that cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: accepts requests.
  - MUL: 32 iterations.
  - DIV: 32 iterations.
  - FIX: sign fix-up and HI/LO write.
- IDLE + `md_start`, op 000/001 -> MUL; op 010/011 -> DIV.
  - Operands are latched at the accepting edge.
  - Signed ops latch operand magnitudes and record the result signs.
  - The 5-bit iteration counter clears.
- IDLE + `md_start`, op 100/101 -> write `hi` or `lo` with `md_src1` at that edge.
  - Stay in IDLE; no busy, no done.
- Op 110/111, or `md_start` outside IDLE: ignored; nothing changes.
- MUL: 64-bit shift-add, one multiplier bit per cycle.
  - After counter reaches 31 -> FIX.
- DIV: restoring division, one quotient bit per cycle (32-bit partial remainder, compare/subtract).
  - After counter reaches 31 -> FIX.
- FIX:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: quotient negative iff dividend and divisor signs differ; remainder takes the dividend's sign.
  - Write {hi,lo} = product, or hi = remainder, lo = quotient.
  - -> IDLE with `md_done` = 1.
- Divide by zero (DIV or DIVU): full latency.
  - lo = 0xFFFFFFFF, hi = `md_src1` unmodified.
  - No sign fix-up applied.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; no trap.
- `md_cancel` in MUL/DIV/FIX -> IDLE at the next edge.
  - `hi`/`lo` unchanged, no `md_done`.
  - `md_cancel` wins over completion in FIX.
  - `md_cancel` in IDLE is ignored, and it does not block a same-cycle MTHI/MTLO or start.
- Reset (async, any state): state = IDLE, `hi` = `lo` = 0, `md_busy` = 0, `md_done` = 0, and counter/operand registers clear.
  - Reset during an operation discards it.

## Timing
- Accepting edge E0 -> `md_busy` is high from after E0 through edge E33 (33 cycles: 32 iterations plus FIX).
- At E33: `hi`/`lo` update, `md_busy` falls, and `md_done` is high for exactly the cycle after E33.
- `md_busy` and `md_done` are never high together.
- A new `md_start` is accepted in the `md_done` cycle (back-to-back ops: period 34 cycles).
- MTHI/MTLO: `hi`/`lo` visible in the cycle after the accepting edge.
- `md_busy` and `md_done` are registered outputs.
- `hi`/`lo` never change except at a FIX completion, an MTHI/MTLO write, or reset.
- Inputs need only be valid in the `md_start` cycle.

## Test plan
- MULT 0xFFFFFFFD × 5 -> `md_busy` high 33 cycles, then `md_done` pulse with hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV 0xFFFFFFF9 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 7 / 0xFFFFFFFE -> lo = 0, hi = 7.
- DIVU 100 / 0 -> lo = 0xFFFFFFFF, hi = 100.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Pulse `md_start` (MULT 2×3) on cycles 5 and 20 after the start -> both ignored, and the original result completes.
- MTLO 0x1234 in the `md_done` cycle -> lo = 0x1234 on the next cycle.
- MULT 6×7 started, then `md_cancel` 10 cycles later -> `md_busy` drops next cycle, no `md_done`, `hi`/`lo` keep their prior values.
- Same op, but `rst` asserted mid-cycle 15 -> immediately hi = lo = 0, `md_busy` = 0, `md_done` = 0.
  - A DIVU 9/4 started after release gives lo = 2, hi = 1.
